// File: rtl/gen3_block_lock_ctrl_pkg.sv
// Shared constants for the Gen3 receive path: generation code, sync-header
// encodings, lane alignment FSM states and LTSSM substate codes.
package gen3_block_lock_ctrl_pkg;

   localparam logic [2:0] GEN3    = 3'd3;
   localparam logic [1:0] SH_DATA = 2'b10;
   localparam logic [1:0] SH_OS   = 2'b01;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lane_state_t;

   // LTSSM substates that sequence descrambler enable around block lock
   localparam logic [3:0] LTSSM_RCV_LOCK   = 4'd0;
   localparam logic [3:0] LTSSM_RCV_CFG    = 4'd1;
   localparam logic [3:0] LTSSM_RCV_IDLE   = 4'd2;
   localparam logic [3:0] LTSSM_RCV_EQ     = 4'd3;
   localparam logic [3:0] LTSSM_RCV_SPEED  = 4'd4;

   function automatic logic sh_is_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_OS);
   endfunction

endpackage

// File: rtl/gen3_block_lock_ctrl_lane.sv
// Single-lane block alignment FSM: hunts for LOCK_COUNT consecutive valid sync
// headers, then holds lock until UNLOCK_COUNT consecutive invalid ones arrive.
module gen3_block_lock_ctrl_lane
   import gen3_block_lock_ctrl_pkg::*;
#(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       header_event,
   input  logic [1:0] sync_header,
   output logic       lane_lock,
   output logic       lock_lost
);

   lane_state_t state_reg, state_next;
   logic [2:0]  good_cnt_reg, good_cnt_next;
   logic [3:0]  bad_cnt_reg, bad_cnt_next;
   logic        lost_reg, lost_next;
   logic        hdr_ok;

   assign hdr_ok = sh_is_valid(sync_header);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= HUNT;
         good_cnt_reg <= 3'd0;
         bad_cnt_reg  <= 4'd0;
         lost_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         good_cnt_reg <= good_cnt_next;
         bad_cnt_reg  <= bad_cnt_next;
         lost_reg     <= lost_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      good_cnt_next = good_cnt_reg;
      bad_cnt_next  = bad_cnt_reg;
      lost_next     = 1'b0;
      // Forced exits (gating/restart) never report a lock loss
      if (!enable) begin
         state_next    = HUNT;
         good_cnt_next = 3'd0;
         bad_cnt_next  = 4'd0;
      end else if (header_event) begin
         case (state_reg)
            HUNT: begin
               if (!hdr_ok) begin
                  good_cnt_next = 3'd0;
               end else if ((int'(good_cnt_reg) + 1) == LOCK_COUNT) begin
                  state_next    = LOCKED;
                  good_cnt_next = 3'd0;
                  bad_cnt_next  = 4'd0;
               end else begin
                  good_cnt_next = good_cnt_reg + 3'd1;
               end
            end
            LOCKED: begin
               if (hdr_ok) begin
                  bad_cnt_next = 4'd0;
               end else if ((int'(bad_cnt_reg) + 1) == UNLOCK_COUNT) begin
                  state_next    = HUNT;
                  good_cnt_next = 3'd0;
                  bad_cnt_next  = 4'd0;
                  lost_next     = 1'b1;
               end else begin
                  bad_cnt_next = bad_cnt_reg + 4'd1;
               end
            end
            default: state_next = HUNT;
         endcase
      end
   end

   assign lane_lock = (state_reg == LOCKED);
   assign lock_lost = lost_reg;

endmodule

// File: rtl/gen3_block_lock_ctrl.sv
// Gen3 block-lock controller: per-lane alignment FSMs, link-wide lock across
// the active lanes and a watchdog that pulses when link lock takes too long.
module gen3_block_lock_ctrl
   import gen3_block_lock_ctrl_pkg::*;
#(
   parameter int LANES          = 16,
   parameter int LOCK_COUNT     = 4,
   parameter int UNLOCK_COUNT   = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         GEN,
   input  logic               restart,
   input  logic [4:0]         numberOfDetectedLanes,
   input  logic [LANES-1:0]   PIPEDataValid,
   input  logic [LANES-1:0]   RxStartBlock,
   input  logic [2*LANES-1:0] PIPESyncHeader,
   output logic [LANES-1:0]   laneLock,
   output logic               linkLock,
   output logic [LANES-1:0]   lockLost,
   output logic               lockTimeout
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic             gen3;
   logic             any_active;
   logic [LANES-1:0] active_mask;
   logic [LANES-1:0] lock_ok;
   logic             link_lock_reg, link_lock_next;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             tmo_pulse_reg;
   logic             tmo_run;

   assign gen3       = (GEN == GEN3);
   assign any_active = (numberOfDetectedLanes != 5'd0);

   // Lane counts above LANES clamp naturally: every lane index is below them
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign active_mask[gi] = (int'(numberOfDetectedLanes) > gi);
         assign lock_ok[gi]     = laneLock[gi] | ~active_mask[gi];

         gen3_block_lock_ctrl_lane #(
            .LOCK_COUNT   (LOCK_COUNT),
            .UNLOCK_COUNT (UNLOCK_COUNT)
         ) u_block_lock_lane (
            .clk          (clk),
            .reset        (reset),
            .enable       (gen3 & active_mask[gi] & ~restart),
            .header_event (PIPEDataValid[gi] & RxStartBlock[gi]),
            .sync_header  (PIPESyncHeader[2*gi +: 2]),
            .lane_lock    (laneLock[gi]),
            .lock_lost    (lockLost[gi])
         );
      end
   endgenerate

   assign link_lock_next = gen3 & any_active & (&lock_ok);
   assign tmo_run        = gen3 & any_active & ~link_lock_reg & ~restart;

   always_ff @(posedge clk) begin
      if (reset) begin
         link_lock_reg <= 1'b0;
         tmo_cnt_reg   <= '0;
         tmo_pulse_reg <= 1'b0;
      end else begin
         link_lock_reg <= link_lock_next;
         tmo_pulse_reg <= 1'b0;
         if (!tmo_run) begin
            tmo_cnt_reg <= '0;
         end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_reg   <= '0;
            tmo_pulse_reg <= 1'b1;
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         end
      end
   end

   assign linkLock    = link_lock_reg;
   assign lockTimeout = tmo_pulse_reg;

endmodule

// File: doc/gen3_block_lock_ctrl.md
Name: gen3_block_lock_ctrl

Overview:
Per-lane Gen3 128b/130b block-alignment controller between the PIPE_Rx_Data stage and the descramblers/LMC_RX.
- Watches the per-lane sync headers at block boundaries and declares per-lane block lock.
- Declares link-wide lock across the active lanes and flags lock loss and lock timeout.
- The RX LTSSM uses these flags to sequence descrambler enable and Recovery entry.

Parameters:
LANES, 16, number of PIPE lanes instantiated.
LOCK_COUNT, 4, consecutive valid sync headers required to acquire lock (range 1..7).
UNLOCK_COUNT, 8, consecutive invalid sync headers required to drop lock (range 1..15).
TIMEOUT_CYCLES, 1024, clk cycles allowed to reach link lock before a timeout pulse.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
GEN  in  3  current generation; value 3 = Gen3 (lock logic active).
restart  in  1  from LTSSM; clears all lock state (Recovery/speed change entry).
numberOfDetectedLanes  in  5  active lanes = lanes 0..N-1; 0 = none, >LANES clamped to LANES.
PIPEDataValid  in  LANES  per-lane data valid.
RxStartBlock  in  LANES  per-lane block start; sync header sampled only when valid & start.
PIPESyncHeader  in  2*LANES  lane i header at bits [2i+1:2i].
laneLock  out  LANES  registered per-lane lock.
linkLock  out  1  registered; all active lanes locked.
lockLost  out  LANES  one-cycle pulse when a lane drops from LOCKED.
lockTimeout  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (sync, high): all lanes HUNT, all counters 0; laneLock=0, linkLock=0, lockLost=0, lockTimeout=0.
- Header event for lane i: PIPEDataValid[i] & RxStartBlock[i]. Valid header = 2'b01 or 2'b10; 2'b00/2'b11 are invalid. Cycles without an event leave lane state unchanged.
- Per-lane FSM, states HUNT and LOCKED, with goodCnt (3b) and badCnt (4b):
  - HUNT: a valid event increments goodCnt. When goodCnt+1 == LOCK_COUNT, go to LOCKED and clear both counters. An invalid event clears goodCnt.
  - LOCKED: a valid event clears badCnt. An invalid event increments badCnt. When badCnt+1 == UNLOCK_COUNT, go to HUNT, clear counters and pulse lockLost[i] next cycle.
- laneLock[i] = (state==LOCKED). It rises the cycle after the LOCK_COUNT-th consecutive valid header is sampled.
- Gating: when GEN!=3, restart=1, or lane i is inactive, lane i is forced to HUNT with counters cleared. lockLost[i] is not pulsed for these forced exits.
  - restart beats a simultaneous header event.
  - Reset beats everything.
- linkLock is registered, one cycle after the laneLock AND over active lanes. It is 0 when there are no active lanes or GEN!=3.
  - Lane-count change mid-operation: newly inactive lanes drop from the AND immediately. Newly active lanes start in HUNT.
- Timeout counter (log2(TIMEOUT_CYCLES)+1 bits):
  - Counts while GEN==3 & active lanes>0 & !linkLock & !restart.
  - On reaching TIMEOUT_CYCLES-1 it pulses lockTimeout for one cycle and wraps to 0.
  - Cleared by reset, restart, linkLock=1, GEN!=3 or no active lanes.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (alongside the LTSSM substate localparams):
  - GEN3 code (3'd3).
  - Sync-header constants SH_DATA=2'b10 and SH_OS=2'b01.
  - Lane FSM encoding HUNT=1'b0, LOCKED=1'b1.
- One natural sub-module, block_lock_lane: the single-lane FSM plus its counters, instantiated LANES times by a generate loop.
- Top level holds the lane-active mask, the linkLock AND and the timeout counter.

Test Plan:
- Acquire: GEN=3, N=2, 4 consecutive 2'b10 events on lanes 0,1 -> laneLock=16'h0003 one cycle after the 4th event; linkLock=1 one cycle later.
- Hunt reset: lane 0 gets valid, valid, 2'b11, then 4 valid -> lock only after the last 4, i.e. 7 events total.
- Lose lock: locked lane 0, 7 invalid then 1 valid then 8 invalid -> lockLost[0] pulses once, after the 8th consecutive invalid. laneLock[0]=0 and linkLock=0.
- Restart collision: restart=1 in the same cycle as the 4th valid event -> laneLock stays 0, counters 0, no lockLost pulse.
- Timeout: GEN=3, N=1, no header events, TIMEOUT_CYCLES=16 -> lockTimeout pulses at cycle 16 and again at cycle 32. Switching GEN=1 clears the counter and suppresses further pulses.
- Lane gating: N=1 with lane 1 receiving only invalid headers -> linkLock follows lane 0 only. Then N=0 -> linkLock=0 next cycle, and N=20 behaves as N=16.
